// File: rtl/param_shift_register.sv
// Parametrised universal shift register: hold, shift right/left, parallel load and rotate,
// with a saturating shift counter and a one-cycle done pulse once a loaded word is shifted out.
module param_shift_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter int               CW          = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             rotate,
    input  logic             serial_in_right,
    input  logic             serial_in_left,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out_right,
    output logic             serial_out_left,
    output logic [CW-1:0]    shift_count,
    output logic             done
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW - 1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_next;
    logic             r_done;
    logic             w_done_next;
    logic             w_shift;
    logic             w_load;
    logic             w_fill_right;
    logic             w_fill_left;

    // Select the bit entering each end: serial input, or the bit leaving the opposite end on rotate.
    always_comb begin
        w_fill_right = serial_in_right;
        w_fill_left  = serial_in_left;
        if (rotate) begin
            w_fill_right = r_q[0];
            w_fill_left  = r_q[WIDTH-1];
        end else begin
            w_fill_right = serial_in_right;
            w_fill_left  = serial_in_left;
        end
    end

    // Data path next state and classification of the current edge as shift or load.
    always_comb begin
        w_q_next = r_q;
        w_shift  = 1'b0;
        w_load   = 1'b0;
        if (en) begin
            case (mode)
                MODE_HOLD: begin
                    w_q_next = r_q;
                end
                MODE_RIGHT: begin
                    w_q_next = {w_fill_right, r_q[WIDTH-1:1]};
                    w_shift  = 1'b1;
                end
                MODE_LEFT: begin
                    w_q_next = {r_q[WIDTH-2:0], w_fill_left};
                    w_shift  = 1'b1;
                end
                MODE_LOAD: begin
                    w_q_next = parallel_in;
                    w_load   = 1'b1;
                end
                default: begin
                    w_q_next = r_q;
                end
            endcase
        end else begin
            w_q_next = r_q;
        end
    end

    // Saturating shift counter; done fires only on the WIDTH-1 -> WIDTH transition so it cannot re-pulse.
    always_comb begin
        w_count_next = r_count;
        w_done_next  = 1'b0;
        if (w_load) begin
            w_count_next = CNT_ZERO;
            w_done_next  = 1'b0;
        end else if (w_shift) begin
            if (r_count < CNT_FULL) begin
                w_count_next = r_count + CNT_ONE;
            end else begin
                w_count_next = CNT_FULL;
            end
            w_done_next = (r_count == CNT_LAST);
        end else begin
            w_count_next = r_count;
            w_done_next  = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q     <= RESET_VALUE;
            r_count <= CNT_ZERO;
            r_done  <= 1'b0;
        end else begin
            r_q     <= w_q_next;
            r_count <= w_count_next;
            r_done  <= w_done_next;
        end
    end

    assign parallel_out     = r_q;
    assign serial_out_right = r_q[0];
    assign serial_out_left  = r_q[WIDTH-1];
    assign shift_count      = r_count;
    assign done             = r_done;

endmodule

// File: tb/tb_param_shift_register.sv
// Scoreboard bench for param_shift_register (WIDTH=8): an arithmetic reference model pushes the
// expected state per edge; a negedge monitor pops and compares. Directed plan plus random traffic.
module tb_param_shift_register;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         en;
    logic [1:0]   mode;
    logic         rotate;
    logic         serial_in_right;
    logic         serial_in_left;
    logic [W-1:0] parallel_in;
    logic [W-1:0] parallel_out;
    logic         serial_out_right;
    logic         serial_out_left;
    logic [3:0]   shift_count;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;
    int m_q     = 0;
    int m_cnt   = 0;
    int pulses;

    typedef struct {
        int q;
        int cnt;
        bit done;
    } exp_t;
    exp_t sb[$];

    param_shift_register #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .rotate(rotate),
        .serial_in_right(serial_in_right), .serial_in_left(serial_in_left),
        .parallel_in(parallel_in), .parallel_out(parallel_out),
        .serial_out_right(serial_out_right), .serial_out_left(serial_out_left),
        .shift_count(shift_count), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one edge of the register expressed with plain arithmetic on an integer word.
    task automatic step(input bit e, input bit [1:0] m, input bit rot, input bit sir,
                        input bit sil, input int pin);
        exp_t x;
        bit   sh;
        bit   dn;
        int   b;
        en = e; mode = m; rotate = rot;
        serial_in_right = sir; serial_in_left = sil;
        parallel_in = pin[7:0];
        sh = 1'b0;
        dn = 1'b0;
        if (e) begin
            case (m)
                2'b01: begin b = rot ? m_q % 2 : int'(sir); m_q = m_q / 2 + b * 128; sh = 1'b1; end
                2'b10: begin b = rot ? m_q / 128 : int'(sil); m_q = (m_q * 2) % 256 + b; sh = 1'b1; end
                2'b11: begin m_q = pin % 256; m_cnt = 0; end
                default: ;
            endcase
        end
        if (sh) begin
            dn = (m_cnt == W - 1);
            if (m_cnt < W) m_cnt++;
        end
        @(posedge clk);
        x.q = m_q; x.cnt = m_cnt; x.done = dn;
        sb.push_back(x);
        #1;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_q", int'(parallel_out), 0);
        chk("async_rst_cnt", int'(shift_count), 0);
        chk("async_rst_done", int'(done), 0);
        m_q = 0; m_cnt = 0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    // Monitor: compare the state presented after each edge against the scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (parallel_out !== e.q[7:0] || shift_count !== 4'(e.cnt) || done !== e.done ||
                serial_out_right !== e.q[0] || serial_out_left !== e.q[7]) begin
                n_fail++;
                $display("FAIL scoreboard @%0t: q=%0h cnt=%0d done=%0b sor=%0b sol=%0b, expected q=%0h cnt=%0d done=%0b",
                         $time, parallel_out, shift_count, done, serial_out_right, serial_out_left,
                         e.q, e.cnt, e.done);
            end
        end
    end

    initial begin
        logic [8:0] lsb_seq;
        lsb_seq = 9'h0A5;
        reset_n = 1'b0; en = 1'b0; mode = 2'b00; rotate = 1'b0;
        serial_in_right = 1'b0; serial_in_left = 1'b0; parallel_in = 8'h00;
        #3;
        chk("reset_q", int'(parallel_out), 0);
        chk("reset_cnt", int'(shift_count), 0);
        chk("reset_done", int'(done), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Async reset mid-shift, then left fill from the reset value.
        step(1, 2'b11, 0, 0, 0, 'hFF);
        for (int i = 0; i < 3; i++) step(1, 2'b01, 0, 1, 0, 0);
        async_reset();
        for (int i = 0; i < 3; i++) step(1, 2'b10, 0, 0, 1, 0);
        chk("left_fill_q", int'(parallel_out), 'h07);
        chk("left_fill_cnt", int'(shift_count), 3);
        chk("left_fill_sol", int'(serial_out_left), 0);

        // LSB-first drain of A5.
        step(1, 2'b11, 0, 0, 0, 'hA5);
        chk("drain_bit0", int'(serial_out_right), int'(lsb_seq[0]));
        for (int k = 1; k <= 8; k++) begin
            step(1, 2'b01, 0, 0, 0, 0);
            chk("drain_bit", int'(serial_out_right), int'(lsb_seq[k]));
            chk("drain_done", int'(done), int'(k == 8));
        end
        chk("drain_q", int'(parallel_out), 0);
        chk("drain_cnt", int'(shift_count), 8);
        step(1, 2'b00, 0, 0, 0, 0);
        chk("drain_done_clr", int'(done), 0);

        // Rotates ignore the serial inputs.
        step(1, 2'b11, 0, 0, 0, 'h81);
        step(1, 2'b01, 1, 0, 0, 0);
        chk("rot_right", int'(parallel_out), 'hC0);
        step(1, 2'b11, 0, 0, 0, 'h81);
        step(1, 2'b10, 1, 0, 0, 0);
        chk("rot_left", int'(parallel_out), 'h03);
        step(1, 2'b11, 0, 0, 0, 'h81);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            step(1, 2'b01, 1, 1, 1, 0);
            pulses += int'(done);
        end
        chk("rot8_q", int'(parallel_out), 'h81);
        chk("rot8_pulses", pulses, 1);

        // Enable low holds, reload re-arms, saturation keeps a single pulse.
        step(1, 2'b11, 0, 0, 0, 'h3C);
        for (int k = 0; k < 5; k++) step(1, 2'b01, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 2'b01, 0, 1, 1, 0);
            chk("en0_q", int'(parallel_out), 'h01);
            chk("en0_cnt", int'(shift_count), 5);
        end
        step(1, 2'b11, 0, 0, 0, 'h3C);
        chk("reload_cnt", int'(shift_count), 0);
        chk("reload_done", int'(done), 0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            step(1, 2'b01, 0, 1, 0, 0);
            pulses += int'(done);
        end
        chk("sat_pulses", pulses, 1);
        chk("sat_cnt", int'(shift_count), 8);

        // Load on the edge that would have been the 8th shift.
        step(1, 2'b11, 0, 0, 0, 'h3C);
        pulses = 0;
        for (int k = 0; k < 7; k++) begin
            step(1, 2'b10, 0, 0, 1, 0);
            pulses += int'(done);
        end
        step(1, 2'b11, 1, 1, 1, 'h5A);
        pulses += int'(done);
        chk("ldwin_q", int'(parallel_out), 'h5A);
        chk("ldwin_cnt", int'(shift_count), 0);
        chk("ldwin_pulses", pulses, 0);

        // Random traffic, shifts biased so the counter regularly saturates.
        for (int k = 0; k < 600; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r == 0) async_reset();
            step($urandom_range(0, 7) != 0,
                 ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 255)));
        end

        for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_shift_register.md
# param_shift_register

Parametrised universal shift register for the serial-datapath library. It replaces the fixed 4-bit right-only SISO stage with a WIDTH-bit register that supports hold, shift right, shift left, parallel load and rotate. A shift counter and a one-cycle `done` pulse let a controller know when a loaded word has been fully shifted out. It sits between parallel producers/consumers and single-wire serial links in either bit order.

## Interface
- `WIDTH`, 8: register width in bits; legal range is 2 and up.
- `RESET_VALUE`, 0: value of `q` after reset; WIDTH bits wide.
- `CW`, $clog2(WIDTH+1): width of `shift_count`; derived, must not be overridden.

- `clk` input 1: the single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `en` input 1: clock enable; when low, all state holds.
- `mode` input 2: 00 = hold, 01 = shift right, 10 = shift left, 11 = parallel load.
- `rotate` input 1: when 1, shifts recirculate the outgoing bit and ignore the serial inputs.
- `serial_in_right` input 1: bit entering `q[WIDTH-1]` on a right shift.
- `serial_in_left` input 1: bit entering `q[0]` on a left shift.
- `parallel_in` input WIDTH: word captured on a load.
- `parallel_out` output WIDTH: current register contents `q`.
- `serial_out_right` output 1: `q[0]` (LSB-first stream).
- `serial_out_left` output 1: `q[WIDTH-1]` (MSB-first stream).
- `shift_count` output CW: number of shifts since the last load; saturates at WIDTH.
- `done` output 1: registered one-cycle pulse when `shift_count` reaches WIDTH.

## Operation
- **Reset** (`reset_n` = 0, asynchronous, takes effect immediately and overrides everything):
  - `q` = RESET_VALUE, `shift_count` = 0, `done` = 0.
  - Serial outputs follow `q` immediately.
- **`en` = 0:** `q` and `shift_count` hold; `done` is cleared to 0.
- **`en` = 1, `mode` 00 (hold):** `q` and `shift_count` hold; `done` = 0.
- **`en` = 1, `mode` 01 (shift right):**
  - `q` ← {X, q[WIDTH-1:1]}.
  - X = `serial_in_right` when `rotate` = 0, else `q[0]`.
- **`en` = 1, `mode` 10 (shift left):**
  - `q` ← {q[WIDTH-2:0], Y}.
  - Y = `serial_in_left` when `rotate` = 0, else `q[WIDTH-1]`.
- **`en` = 1, `mode` 11 (load):**
  - `q` ← `parallel_in`; `shift_count` ← 0; `done` = 0.
  - `rotate` and the serial inputs are ignored.
- **Shift counting** (modes 01 and 10 only):
  - `shift_count` increments by 1 while below WIDTH, otherwise holds at WIDTH.
  - Counting is direction-agnostic: mixing left and right shifts still counts each shift.
  - Rotates count the same as shifts.
- **`done`:**
  - Set to 1 on the edge where `shift_count` goes from WIDTH-1 to WIDTH; 0 on every other edge.
  - Further shifts at saturation keep shifting data but never re-pulse `done`.
  - A new load re-arms it.
- Serial outputs and `parallel_out` are direct taps of `q`, with no extra logic.

## Timing
- Load or shift takes effect at the first rising edge with `en` = 1; new `q` is visible on all outputs in the same cycle after that edge.
- `shift_count` and `done` are registered and update on the same edge as `q`.
- `done` is high for exactly one clock cycle, the cycle immediately after the WIDTH-th shift edge.
- An `en`/`mode` change takes effect at the next edge; there is no pipeline delay.
- Reset asserted mid-shift: outputs clear asynchronously.
  - After deassertion, the first active edge acts normally, starting from RESET_VALUE with count 0.
  - No `done` is produced for a partially shifted word.
- A load in the same cycle that would have been the WIDTH-th shift: the load wins, and there is no `done`.

## Test plan
All scenarios use WIDTH = 8 and RESET_VALUE = 0.

1. **Async reset:** load 8'hFF, shift 3 times, then pull `reset_n` low between edges → `q` = 00, `shift_count` = 0, `done` = 0 without waiting for a clock edge; after release, the first edge behaves normally.
2. **LSB-first drain:** load 8'hA5, then 8 right shifts with `serial_in_right` = 0 → `serial_out_right` after load and each shift reads 1,0,1,0,0,1,0,1,0; `q` ends at 00; `done` is high only in the cycle after the 8th shift; `shift_count` = 8.
3. **Rotate:** load 8'h81, one right rotate → 8'hC0. Reload 8'h81, one left rotate → 8'h03. After 8 right rotates from 8'h81 → `q` returns to 8'h81 and `done` pulses once.
4. **Left fill:** from reset, 3 left shifts with `serial_in_left` = 1 → `q` = 8'h07, `shift_count` = 3, `serial_out_left` = 0.
5. **Enable, reload and saturation:**
   - Load 8'h3C, shift 5 times, then hold `en` = 0 for 4 cycles with `mode` = 01 → `q` and `shift_count` (5) are unchanged.
   - Load 8'h3C again → `shift_count` = 0 with no `done`.
   - Then shift 10 times → `done` pulses exactly once (after shift 8) and `shift_count` stays at 8.
6. **Load vs. final shift:** load, shift 7 times, then apply `mode` = 11 with `parallel_in` = 8'h5A on the next edge → `q` = 8'h5A, `shift_count` = 0, `done` never asserted.
